background_scroll_ctrl: RTL and testbench

Sequences the vertically scrolling game background: converts the VGA beam position into a background ROM address with a per-frame scroll offset. It forwards the returned 4-bit colour index to the 16-entry background palette lookup and registers the resulting 12-bit RGB, aligned to the video-enable signal. It sits between the VGA timing generator and the colour mux that overlays jets and bullets.

---
 rtl/background_scroll_ctrl.sv | 134 +++++++++++++
 tb/tb_background_scroll_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/background_scroll_ctrl.sv
// rtl/background_scroll_ctrl.sv - vertically scrolling background address/colour pipeline
//
// Maps the VGA beam position (640x480, 2x upscaled) onto a 320x240 background
// ROM. A per-frame row offset makes the picture move downward. The returned
// colour index goes through the palette, and the RGB output is registered three
// clocks after the beam position.
//
// Ports:
//   clk, reset_n               pixel clock, asynchronous active-low reset
//   draw_x, draw_y, vde        beam position and active-video flag
//   frame_start                one-cycle pulse at the start of vertical blank
//   scroll_en, frame_div       scroll request and frames-per-step minus one
//   scroll_rst                 one-cycle pulse that returns the offset to 0
//   rom_addr / rom_q           background ROM address and colour index (1-cycle ROM)
//   pal_index / pal_*          palette lookup index and returned colour
//   red, green, blue           registered pixel colour
//   scroll_offset              current offset in image rows
module background_scroll_ctrl #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              vde,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [3:0]        frame_div,
  input  logic              scroll_rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic [7:0]        scroll_offset
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  logic [3:0]        frame_cnt, cnt_nx;
  logic [7:0]        offset_nx, offset_dec;
  logic [8:0]        x_img, y_img, row;
  logic [9:0]        row_sum;
  logic [ADDR_W-1:0] addr_nx;
  logic              vde_d1, vde_d2;
  logic              unused_lsbs;

  // The image is drawn 2x upscaled, so the beam LSBs never select a pixel.
  assign unused_lsbs = draw_x[0] ^ draw_y[0];

  assign x_img   = draw_x[9:1];
  assign y_img   = draw_y[9:1];
  assign row_sum = {1'b0, y_img} + {2'b00, scroll_offset};
  // Both operands are below IMG_H, so a single conditional subtract wraps.
  assign row     = (row_sum >= 10'(IMG_H)) ? 9'(row_sum - 10'(IMG_H)) : row_sum[8:0];
  assign addr_nx = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(x_img);

  // Decrementing the offset moves the picture downward on screen.
  assign offset_dec = (scroll_offset == 8'd0) ? 8'(IMG_H - 1) : scroll_offset - 8'd1;

  always_comb begin
    state_nx  = state;
    offset_nx = scroll_offset;
    cnt_nx    = frame_cnt;
    if (frame_start) begin
      case (state)
        IDLE: begin
          // Entering RUN does not step; the first step comes frame_div+1 frames later.
          if (scroll_en) begin
            state_nx = RUN;
            cnt_nx   = 4'd0;
          end
        end
        RUN: begin
          if (!scroll_en) begin
            state_nx = IDLE;
          end else if (frame_cnt == frame_div) begin
            offset_nx = offset_dec;
            cnt_nx    = 4'd0;
          end else begin
            cnt_nx = frame_cnt + 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // scroll_rst overrides any step in the same cycle but leaves the state alone.
    if (scroll_rst) begin
      offset_nx = 8'd0;
      cnt_nx    = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      scroll_offset <= 8'd0;
      frame_cnt     <= 4'd0;
    end else begin
      state         <= state_nx;
      scroll_offset <= offset_nx;
      frame_cnt     <= cnt_nx;
    end
  end

  assign pal_index = rom_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      vde_d1   <= 1'b0;
      vde_d2   <= 1'b0;
      red      <= 4'd0;
      green    <= 4'd0;
      blue     <= 4'd0;
    end else begin
      if (vde) rom_addr <= addr_nx;
      vde_d1 <= vde;
      vde_d2 <= vde_d1;
      // vde_d2 lines up with the palette colour of the address registered two clocks ago.
      red    <= vde_d2 ? pal_red   : 4'd0;
      green  <= vde_d2 ? pal_green : 4'd0;
      blue   <= vde_d2 ? pal_blue  : 4'd0;
    end
  end

endmodule

// File: tb/tb_background_scroll_ctrl.sv
// tb/tb_background_scroll_ctrl.sv - self-checking bench for background_scroll_ctrl
module tb_background_scroll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y;
  logic        vde, frame_start, scroll_en, scroll_rst;
  logic [3:0]  frame_div;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q = 4'd0;
  logic [3:0]  pal_index, pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic [7:0]  scroll_offset;

  int n_vec = 0;
  int n_bad = 0;
  bit force_colour = 1'b1;
  bit check_en     = 1'b0;

  always #5 clk = ~clk;

  background_scroll_ctrl #(.IMG_W(320), .IMG_H(240), .ADDR_W(17)) dut (
    .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y), .vde(vde),
    .frame_start(frame_start), .scroll_en(scroll_en), .frame_div(frame_div),
    .scroll_rst(scroll_rst), .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .scroll_offset(scroll_offset)
  );

  function automatic int rom_fn(int a);
    return (a ^ (a >> 5) ^ (a >> 11)) & 15;
  endfunction
  function automatic int pr(int i); return (i * 3) & 15; endfunction
  function automatic int pg(int i); return (~i) & 15;    endfunction
  function automatic int pb(int i); return i ^ 10;       endfunction

  // Environment: 1-cycle ROM and combinational palette.
  always @(posedge clk) rom_q <= force_colour ? 4'hB : 4'(rom_fn(int'(rom_addr)));
  assign pal_red   = force_colour ? 4'hF : 4'(pr(int'(pal_index)));
  assign pal_green = force_colour ? 4'hF : 4'(pg(int'(pal_index)));
  assign pal_blue  = force_colour ? 4'hF : 4'(pb(int'(pal_index)));

  // Reference model: addresses and vde over the last three edges, plus offset rules.
  int m_off, m_cnt, since;
  bit m_run;
  int a0, a1, a2;
  bit v0, v1, v2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_off = 0; m_cnt = 0; m_run = 0; since = 0;
      a0 = 0; a1 = 0; a2 = 0; v0 = 0; v1 = 0; v2 = 0;
    end else begin
      a2 = a1; a1 = a0; v2 = v1; v1 = v0; v0 = vde;
      if (vde) a0 = ((int'(draw_y) / 2 + m_off) % 240) * 320 + int'(draw_x) / 2;
      since++;
      if (frame_start) begin
        if (!m_run) begin
          if (scroll_en) begin m_run = 1; m_cnt = 0; end
        end else if (!scroll_en) begin
          m_run = 0;
        end else if (m_cnt == int'(frame_div)) begin
          m_off = (m_off + 239) % 240; m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1) % 16;
        end
      end
      if (scroll_rst) begin m_off = 0; m_cnt = 0; end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("rom_addr", int'(rom_addr), a0);
      chk("scroll_offset", int'(scroll_offset), m_off);
      if (since >= 1) chk("pal_index", int'(pal_index), rom_fn(a1));
      chk("red",   int'(red),   v2 ? pr(rom_fn(a2)) : 0);
      chk("green", int'(green), v2 ? pg(rom_fn(a2)) : 0);
      chk("blue",  int'(blue),  v2 ? pb(rom_fn(a2)) : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin : stim
    int exp_div [6] = '{239, 239, 238, 238, 238, 237};
    reset_n = 1'b0; draw_x = '0; draw_y = '0; vde = 1'b0; frame_start = 1'b0;
    scroll_en = 1'b0; frame_div = 4'd0; scroll_rst = 1'b0;
    step(); step();
    chk("reset rom_addr", int'(rom_addr), 0);
    chk("reset red", int'(red), 0);
    chk("reset offset", int'(scroll_offset), 0);
    reset_n = 1'b1;

    // Address and colour path.
    vde = 1'b1; draw_x = 10'd5; draw_y = 10'd3;
    step();
    chk("addr 5,3", int'(rom_addr), 322);
    chk("red cyc1", int'(red), 0);
    step();
    chk("pal_index cyc2", int'(pal_index), 11);
    chk("red cyc2", int'(red), 0);
    step();
    chk("red cyc3", int'(red), 15);
    chk("green cyc3", int'(green), 15);
    chk("blue cyc3", int'(blue), 15);
    vde = 1'b0;
    step(); step(); step();
    chk("red vde0", int'(red), 0);
    chk("green vde0", int'(green), 0);
    chk("blue vde0", int'(blue), 0);
    chk("addr hold", int'(rom_addr), 322);

    // Wrap.
    scroll_en = 1'b1; frame_div = 4'd0;
    pulse(); chk("enter run no step", int'(scroll_offset), 0);
    pulse(); chk("wrap 0->239", int'(scroll_offset), 239);
    vde = 1'b1; draw_x = 10'd0; draw_y = 10'd0;
    step(); chk("addr row 239", int'(rom_addr), 76480);
    draw_y = 10'd2;
    step(); chk("addr row wrap", int'(rom_addr), 0);
    vde = 1'b0;

    // Divider.
    frame_div = 4'd2;
    for (int i = 0; i < 6; i++) begin
      pulse(); chk($sformatf("div pulse %0d", i + 1), int'(scroll_offset), exp_div[i]);
    end
    scroll_en = 1'b0;
    pulse(); chk("to idle", int'(scroll_offset), 237);
    for (int i = 0; i < 4; i++) begin
      pulse(); chk($sformatf("idle hold %0d", i), int'(scroll_offset), 237);
    end

    // Collision of scroll_rst with a stepping frame_start.
    scroll_en = 1'b1;
    pulse();
    frame_div = 4'd0;
    for (int i = 0; i < 227; i++) pulse();
    chk("offset 10", int'(scroll_offset), 10);
    frame_div = 4'd1; frame_start = 1'b1; scroll_rst = 1'b1;
    step();
    frame_start = 1'b0; scroll_rst = 1'b0;
    chk("collision offset", int'(scroll_offset), 0);
    pulse(); chk("cnt cleared", int'(scroll_offset), 0);
    pulse(); chk("still run", int'(scroll_offset), 239);

    // Asynchronous reset mid-frame.
    frame_div = 4'd0;
    for (int i = 0; i < 182; i++) pulse();
    chk("offset 57", int'(scroll_offset), 57);
    vde = 1'b1; draw_x = 10'd100; draw_y = 10'd50;
    step(); step(); step();
    chk("red before reset", int'(red), 15);
    reset_n = 1'b0;
    #1;
    chk("async red", int'(red), 0);
    chk("async rom_addr", int'(rom_addr), 0);
    chk("async offset", int'(scroll_offset), 0);
    #1;
    reset_n = 1'b1;
    vde = 1'b0;
    pulse(); chk("idle after reset", int'(scroll_offset), 0);
    pulse(); chk("run after reset", int'(scroll_offset), 239);

    // Randomised phase against the model.
    force_colour = 1'b0;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check_en = 1'b1;
    scroll_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      draw_x      = 10'($urandom_range(639));
      draw_y      = 10'($urandom_range(479));
      vde         = ($urandom_range(3) != 0);
      frame_start = ($urandom_range(7) == 0);
      scroll_rst  = ($urandom_range(79) == 0);
      if ($urandom_range(63) == 0) scroll_en = ~scroll_en;
      if ($urandom_range(15) == 0) frame_div = 4'($urandom_range(3));
      if (i == 1500) begin
        #2 reset_n = 1'b0;
        step(); step();
        reset_n = 1'b1;
      end
      step();
    end
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
